tilt_decoder: RTL

Producer side of the ball-movement command interface. Takes signed accelerometer X/Y samples and turns them into the level signals the ball block consumes: x_increment, x_decrement, y_increment, y_decrement. Each axis is filtered through a deadband, hysteresis and N-sample confirmation so sensor noise never produces spurious moves. It sits between the accelerometer sampling front end and the ball position logic.

---
 rtl/tilt_pkg.sv | 20 ++
 rtl/tilt_axis_fsm.sv | 80 ++++++++
 rtl/tilt_decoder.sv | 86 ++++++++
 3 files changed

// File: rtl/tilt_pkg.sv
// tilt_pkg: shared axis state encoding and threshold/timeout helpers for the tilt decoder.
package tilt_pkg;

    typedef enum logic [2:0] {
        NEUTRAL  = 3'd0,
        PEND_POS = 3'd1,
        POS      = 3'd2,
        PEND_NEG = 3'd3,
        NEG      = 3'd4
    } axis_state_e;

    function automatic int t_on(input int deadband, input int hyst);
        return deadband + hyst;
    endfunction

    function automatic int stale_limit(input int simulate, input int sim_cnt, input int cycles);
        return (simulate != 0) ? sim_cnt : cycles;
    endfunction

endpackage

// File: rtl/tilt_axis_fsm.sv
// tilt_axis_fsm: deadband/hysteresis/confirmation state machine for one tilt axis.
module tilt_axis_fsm
    import tilt_pkg::*;
#(
    parameter int DATA_WIDTH      = 12,
    parameter int DEADBAND        = 64,
    parameter int HYST            = 16,
    parameter int CONFIRM_SAMPLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic                  force_i,
    input  logic signed [DATA_WIDTH:0] s_i,
    output logic                  pos_o,
    output logic                  neg_o
);

    localparam logic signed [DATA_WIDTH:0] TON  = (DATA_WIDTH+1)'(t_on(DEADBAND, HYST));
    localparam logic signed [DATA_WIDTH:0] TOFF = (DATA_WIDTH+1)'(DEADBAND);
    localparam logic [3:0] CONF = 4'(CONFIRM_SAMPLES);

    axis_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        hi, lo;

    assign hi = s_i > TON;
    assign lo = s_i < -TON;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_i) begin
            state_d = NEUTRAL;
            cnt_d   = '0;
        end else if (valid_i) begin
            case (state_q)
                NEUTRAL: begin
                    if (hi) begin
                        state_d = (CONF == 4'd1) ? POS : PEND_POS;
                        cnt_d   = (CONF == 4'd1) ? 4'd0 : 4'd1;
                    end else if (lo) begin
                        state_d = (CONF == 4'd1) ? NEG : PEND_NEG;
                        cnt_d   = (CONF == 4'd1) ? 4'd0 : 4'd1;
                    end
                end
                PEND_POS: begin
                    state_d = !hi ? NEUTRAL : (cnt_q + 4'd1 == CONF) ? POS : PEND_POS;
                    cnt_d   = (!hi || cnt_q + 4'd1 == CONF) ? 4'd0 : cnt_q + 4'd1;
                end
                PEND_NEG: begin
                    state_d = !lo ? NEUTRAL : (cnt_q + 4'd1 == CONF) ? NEG : PEND_NEG;
                    cnt_d   = (!lo || cnt_q + 4'd1 == CONF) ? 4'd0 : cnt_q + 4'd1;
                end
                // Between T_OFF and T_ON the confirmed direction is held.
                POS:     state_d = (s_i <= TOFF) ? NEUTRAL : POS;
                NEG:     state_d = (s_i >= -TOFF) ? NEUTRAL : NEG;
                default: begin
                    state_d = NEUTRAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= NEUTRAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state levels so the top's output registers track the state with one-cycle latency.
    assign pos_o = state_d == POS;
    assign neg_o = state_d == NEG;

endmodule

// File: rtl/tilt_decoder.sv
// tilt_decoder: turns signed accelerometer X/Y samples into debounced ball-movement levels,
// with sample inversion, a stale-input timeout and registered direction outputs.
module tilt_decoder
    import tilt_pkg::*;
#(
    parameter int DATA_WIDTH         = 12,
    parameter int DEADBAND           = 64,
    parameter int HYST               = 16,
    parameter int CONFIRM_SAMPLES    = 3,
    parameter int INVERT_X           = 0,
    parameter int INVERT_Y           = 0,
    parameter int STALE_CYCLES       = 2000000,
    parameter int SIMULATE           = 0,
    parameter int SIMULATE_STALE_CNT = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] accel_x,
    input  logic signed [DATA_WIDTH-1:0] accel_y,
    output logic                         x_increment,
    output logic                         x_decrement,
    output logic                         y_increment,
    output logic                         y_decrement,
    output logic                         stale
);

    localparam int LIMIT = stale_limit(SIMULATE, SIMULATE_STALE_CNT, STALE_CYCLES);
    localparam int CW    = $clog2(LIMIT);
    localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);

    logic signed [DATA_WIDTH:0] sx, sy;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stale_q, stale_d, expire;
    logic          x_pos, x_neg, y_pos, y_neg;
    logic          x_inc_q, x_dec_q, y_inc_q, y_dec_q;

    // One extra bit so negating the most negative sample cannot wrap.
    assign sx = (INVERT_X != 0) ? -{accel_x[DATA_WIDTH-1], accel_x} : {accel_x[DATA_WIDTH-1], accel_x};
    assign sy = (INVERT_Y != 0) ? -{accel_y[DATA_WIDTH-1], accel_y} : {accel_y[DATA_WIDTH-1], accel_y};

    always_comb begin
        cnt_d   = sample_valid ? '0 : (cnt_q == TOP) ? cnt_q : cnt_q + 1'b1;
        expire  = !sample_valid && (cnt_d == TOP);
        stale_d = sample_valid ? 1'b0 : (expire | stale_q);
    end

    tilt_axis_fsm #(
        .DATA_WIDTH(DATA_WIDTH), .DEADBAND(DEADBAND), .HYST(HYST), .CONFIRM_SAMPLES(CONFIRM_SAMPLES)
    ) u_x (
        .clk_i(clk), .rst_ni(reset), .valid_i(sample_valid), .force_i(expire),
        .s_i(sx), .pos_o(x_pos), .neg_o(x_neg)
    );

    tilt_axis_fsm #(
        .DATA_WIDTH(DATA_WIDTH), .DEADBAND(DEADBAND), .HYST(HYST), .CONFIRM_SAMPLES(CONFIRM_SAMPLES)
    ) u_y (
        .clk_i(clk), .rst_ni(reset), .valid_i(sample_valid), .force_i(expire),
        .s_i(sy), .pos_o(y_pos), .neg_o(y_neg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            stale_q <= 1'b1;
            x_inc_q <= 1'b0;
            x_dec_q <= 1'b0;
            y_inc_q <= 1'b0;
            y_dec_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
            x_inc_q <= x_pos && !stale_d;
            x_dec_q <= x_neg && !stale_d;
            y_inc_q <= y_pos && !stale_d;
            y_dec_q <= y_neg && !stale_d;
        end
    end

    assign x_increment = x_inc_q;
    assign x_decrement = x_dec_q;
    assign y_increment = y_inc_q;
    assign y_decrement = y_dec_q;
    assign stale       = stale_q;

endmodule
